// File: rtl/regfile_scalar_wb_sched.sv
// Write-back arbiter, registered RF write stage and per-register pending scoreboard.
// Define TINYGPU_RF_WB_BYPASS_EN to add the write-cycle forwarding outputs.
module regfile_scalar_wb_sched #(
  parameter int NUM_REQ = 3,
  parameter int CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*5-1:0]  req_waddr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  input  logic                  sb_set,
  input  logic [4:0]            sb_set_addr,
  output logic                  sb_set_ready,
  input  logic [4:0]            chk_addr_a,
  input  logic [4:0]            chk_addr_b,
  input  logic [4:0]            chk_addr_c,
  output logic                  chk_busy_a,
  output logic                  chk_busy_b,
  output logic                  chk_busy_c
`ifdef TINYGPU_RF_WB_BYPASS_EN
  ,
  output logic                  fwd_valid_a,
  output logic                  fwd_valid_b,
  output logic                  fwd_valid_c,
  output logic [31:0]           fwd_data_a,
  output logic [31:0]           fwd_data_b,
  output logic [31:0]           fwd_data_c
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];

  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [4:0]         sel_waddr;
  logic [31:0]        sel_wdata;
  logic               inc_en;

  logic [4:0] chk_addr [3];
  logic [2:0] busy;

  assign chk_addr[0] = chk_addr_a;
  assign chk_addr[1] = chk_addr_b;
  assign chk_addr[2] = chk_addr_c;

  // round-robin pick: first valid requester at or after rr_ptr
  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
    if (!rst_n) gnt_any = 1'b0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt;
  assign sel_waddr = req_waddr[int'(gnt_idx)*5 +: 5];
  assign sel_wdata = req_wdata[int'(gnt_idx)*32 +: 32];

  // next pointer and write-stage inputs; x0 grants retire silently
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_any) begin
      rr_ptr_d   = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);
      rf_we_d    = (sel_waddr != 5'd0);
      rf_waddr_d = sel_waddr;
      rf_wdata_d = sel_wdata;
    end
  end

  // a slot opens when the register is retiring a write this cycle
  assign sb_set_ready = (sb_set_addr == 5'd0)
                     || (cnt_q[sb_set_addr] != CNT_MAX)
                     || (rf_we_q && rf_waddr_q == sb_set_addr);

  assign inc_en = sb_set && sb_set_ready && (sb_set_addr != 5'd0);

  // pending counters: +1 on dispatch, -1 on write-back, both cancel
  always_comb begin
    logic inc, dec;
    inc   = 1'b0;
    dec   = 1'b0;
    cnt_d = cnt_q;
    for (int r = 1; r < 32; r++) begin
      inc = inc_en && (sb_set_addr == 5'(r));
      dec = rf_we_q && (rf_waddr_q == 5'(r));
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (dec && !inc && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end
  end

  // hazard lookup for the three issue sources
  always_comb begin
    busy = '0;
`ifdef TINYGPU_RF_WB_BYPASS_EN
    fwd_valid_a = 1'b0;
    fwd_valid_b = 1'b0;
    fwd_valid_c = 1'b0;
    fwd_data_a  = '0;
    fwd_data_b  = '0;
    fwd_data_c  = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      busy[i] = (chk_addr[i] != 5'd0) && (cnt_q[chk_addr[i]] != '0);
    end
`ifdef TINYGPU_RF_WB_BYPASS_EN
    if (rf_we_q && rf_waddr_q == chk_addr_a && chk_addr_a != 5'd0
        && cnt_q[chk_addr_a] == CNT_W'(1)) begin
      fwd_valid_a = 1'b1;
      fwd_data_a  = rf_wdata_q;
      busy[0]     = 1'b0;
    end
    if (rf_we_q && rf_waddr_q == chk_addr_b && chk_addr_b != 5'd0
        && cnt_q[chk_addr_b] == CNT_W'(1)) begin
      fwd_valid_b = 1'b1;
      fwd_data_b  = rf_wdata_q;
      busy[1]     = 1'b0;
    end
    if (rf_we_q && rf_waddr_q == chk_addr_c && chk_addr_c != 5'd0
        && cnt_q[chk_addr_c] == CNT_W'(1)) begin
      fwd_valid_c = 1'b1;
      fwd_data_c  = rf_wdata_q;
      busy[2]     = 1'b0;
    end
`endif
  end

  assign chk_busy_a = busy[0];
  assign chk_busy_b = busy[1];
  assign chk_busy_c = busy[2];

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // state registers, synchronous reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

`ifndef SYNTHESIS
  // a write-back must retire a register that was marked pending
  always_ff @(posedge clk) begin
    if (rst_n && rf_we_q) begin
      assert (cnt_q[rf_waddr_q] != '0
              || (inc_en && sb_set_addr == rf_waddr_q))
        else $error("write-back to r%0d with no pending entry", rf_waddr_q);
    end
  end
`endif

endmodule

// File: tb/tb_regfile_scalar_wb_sched.sv
// Bench for regfile_scalar_wb_sched: vector table plus hand sequences,
// expected RF writes queued at grant time and matched when rf_we fires.
module tb_regfile_scalar_wb_sched;

`ifdef TINYGPU_RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_waddr;
  logic [95:0] req_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic        sb_set_ready;
  logic [4:0]  chk_addr_a, chk_addr_b, chk_addr_c;
  logic        chk_busy_a, chk_busy_b, chk_busy_c;
`ifdef TINYGPU_RF_WB_BYPASS_EN
  logic        fwd_valid_a, fwd_valid_b, fwd_valid_c;
  logic [31:0] fwd_data_a, fwd_data_b, fwd_data_c;
`endif

  logic [4:0]  wa [3];
  logic [31:0] wd [3];

  assign req_waddr = {wa[2], wa[1], wa[0]};
  assign req_wdata = {wd[2], wd[1], wd[0]};

  regfile_scalar_wb_sched #(.NUM_REQ(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .sb_set_ready(sb_set_ready),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .chk_addr_c(chk_addr_c),
    .chk_busy_a(chk_busy_a), .chk_busy_b(chk_busy_b),
    .chk_busy_c(chk_busy_c)
`ifdef TINYGPU_RF_WB_BYPASS_EN
    ,
    .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b),
    .fwd_valid_c(fwd_valid_c),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
    .fwd_data_c(fwd_data_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  typedef struct packed {
    logic [2:0] valid;
    logic       set;
    logic [4:0] saddr;
    logic [4:0] chka;
    logic [2:0] exp_ready;
    logic       exp_sr;
    logic       exp_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // queue the write a grant should produce one cycle later
  task automatic expect_grant(logic [2:0] g);
    for (int i = 0; i < 3; i++) begin
      if (g[i] && wa[i] != 5'd0) exp_q.push_back({wa[i], wd[i]});
    end
  endtask

  task automatic bump(logic [2:0] g);
    for (int i = 0; i < 3; i++) begin
      if (g[i]) wd[i] = wd[i] + 32'd1;
    end
  endtask

  task automatic add(logic [2:0] v, logic s, logic [4:0] sa,
                     logic [4:0] ca, logic [2:0] er, logic esr,
                     logic eb);
    tbl.push_back({v, s, sa, ca, er, esr, eb});
  endtask

  // match every RF write against the queue of expected writes
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL wr_unexpected: got write r%0d data %h want none",
                 rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, rf_waddr}, {27'd0, e.a});
        check("wr_data", rf_wdata, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 3'b111;
    sb_set = 1'b0;
    sb_set_addr = 5'd0;
    wa[0] = 5'd1; wa[1] = 5'd2; wa[2] = 5'd3;
    wd[0] = 32'hA000_0000;
    wd[1] = 32'hA001_0000;
    wd[2] = 32'hA002_0000;
    chk_addr_a = 5'd1; chk_addr_b = 5'd2; chk_addr_c = 5'd3;

    // vector table: preload r1..r3, then round robin incl. wrap cases
    for (int k = 0; k < 3; k++)
      add(3'b000, 1'b1, 5'd1, 5'd1, 3'b000, 1'b1, k != 0);
    for (int k = 0; k < 3; k++)
      add(3'b000, 1'b1, 5'd2, 5'd1, 3'b000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++)
      add(3'b000, 1'b1, 5'd3, 5'd1, 3'b000, 1'b1, 1'b1);
    add(3'b111, 1'b0, 5'd1, 5'd1, 3'b001, 1'b0, 1'b1);
    add(3'b111, 1'b0, 5'd1, 5'd1, 3'b010, 1'b1, 1'b1);
    add(3'b111, 1'b0, 5'd0, 5'd1, 3'b100, 1'b1, 1'b1);
    add(3'b111, 1'b0, 5'd0, 5'd1, 3'b001, 1'b1, 1'b1);
    add(3'b111, 1'b0, 5'd0, 5'd1, 3'b010, 1'b1, 1'b1);
    add(3'b111, 1'b0, 5'd0, 5'd1, 3'b100, 1'b1, 1'b1);
    add(3'b100, 1'b0, 5'd0, 5'd1, 3'b100, 1'b1, 1'b1);
    add(3'b110, 1'b0, 5'd0, 5'd1, 3'b010, 1'b1, 1'b1);
    add(3'b011, 1'b0, 5'd0, 5'd1, 3'b001, 1'b1, 1'b1);
    add(3'b000, 1'b0, 5'd0, 5'd1, 3'b000, 1'b1, !BYP);
    add(3'b000, 1'b0, 5'd0, 5'd1, 3'b000, 1'b1, 1'b0);

    // reset held with all requesters valid
    tick(); tick(); tick();
    settle();
    check("rst_ready", {29'd0, req_ready}, 32'd0);
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_busy_a", {31'd0, chk_busy_a}, 32'd0);
    check("rst_busy_b", {31'd0, chk_busy_b}, 32'd0);
    check("rst_busy_c", {31'd0, chk_busy_c}, 32'd0);

    // release: requester 0 wins first
    rst_n = 1'b1;
    sb_set = 1'b1; sb_set_addr = 5'd1;
    settle();
    check("rel_ready", {29'd0, req_ready}, 32'd1);
    expect_grant(3'b001);
    tick();
    bump(3'b001);
    req_valid = 3'b000; sb_set = 1'b0;
    settle();
    check("rel_busy_wcyc", {31'd0, chk_busy_a}, {31'd0, !BYP});
    tick();
    settle();
    check("rel_busy_after", {31'd0, chk_busy_a}, 32'd0);

    // fresh reset so round robin starts at 0
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    foreach (tbl[n]) begin
      req_valid   = tbl[n].valid;
      sb_set      = tbl[n].set;
      sb_set_addr = tbl[n].saddr;
      chk_addr_a  = tbl[n].chka;
      settle();
      check($sformatf("v%0d_ready", n), {29'd0, req_ready},
            {29'd0, tbl[n].exp_ready});
      check($sformatf("v%0d_setrdy", n), {31'd0, sb_set_ready},
            {31'd0, tbl[n].exp_sr});
      check($sformatf("v%0d_busy", n), {31'd0, chk_busy_a},
            {31'd0, tbl[n].exp_busy});
      expect_grant(tbl[n].exp_ready);
      tick();
      bump(tbl[n].exp_ready);
    end
    req_valid = 3'b000; sb_set = 1'b0;

    // two pending writes to r5 retire one at a time
    chk_addr_b = 5'd5;
    sb_set = 1'b1; sb_set_addr = 5'd5;
    settle();
    check("sb5_busy0", {31'd0, chk_busy_b}, 32'd0);
    tick();
    settle();
    check("sb5_busy1", {31'd0, chk_busy_b}, 32'd1);
    tick();
    sb_set = 1'b0;
    wa[0] = 5'd5; wd[0] = 32'h5555_5555; req_valid = 3'b001;
    settle();
    check("sb5_g1", {29'd0, req_ready}, 32'd1);
    check("sb5_busy2", {31'd0, chk_busy_b}, 32'd1);
    expect_grant(3'b001);
    tick();
    req_valid = 3'b000;
    settle();
    check("sb5_busy3", {31'd0, chk_busy_b}, 32'd1);
    tick();
    wd[0] = 32'h6666_6666; req_valid = 3'b001;
    settle();
    check("sb5_g2", {29'd0, req_ready}, 32'd1);
    check("sb5_busy4", {31'd0, chk_busy_b}, 32'd1);
    expect_grant(3'b001);
    tick();
    req_valid = 3'b000;
    settle();
    check("sb5_busy_wcyc", {31'd0, chk_busy_b}, {31'd0, !BYP});
    tick();
    settle();
    check("sb5_busy_done", {31'd0, chk_busy_b}, 32'd0);

    // saturation of r7
    chk_addr_c = 5'd7;
    for (int k = 0; k < 3; k++) begin
      sb_set = 1'b1; sb_set_addr = 5'd7;
      settle();
      check($sformatf("sat_set%0d", k), {31'd0, sb_set_ready}, 32'd1);
      tick();
    end
    settle();
    check("sat_full", {31'd0, sb_set_ready}, 32'd0);
    tick();
    sb_set = 1'b0;
    wa[1] = 5'd7; wd[1] = 32'h7777_0001; req_valid = 3'b010;
    settle();
    check("sat_g", {29'd0, req_ready}, 32'd2);
    expect_grant(3'b010);
    tick();
    req_valid = 3'b000;
    sb_set = 1'b1;
    settle();
    check("sat_coinc", {31'd0, sb_set_ready}, 32'd1);
    tick();
    sb_set = 1'b0;
    settle();
    check("sat_still", {31'd0, sb_set_ready}, 32'd0);
    check("sat_busy", {31'd0, chk_busy_c}, 32'd1);
    tick();
    req_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      settle();
      check($sformatf("sat_drain%0d", k), {29'd0, req_ready}, 32'd2);
      expect_grant(3'b010);
      tick();
      bump(3'b010);
    end
    req_valid = 3'b000;
    settle();
    check("sat_busy_wcyc", {31'd0, chk_busy_c}, {31'd0, !BYP});
    tick();
    settle();
    check("sat_busy_done", {31'd0, chk_busy_c}, 32'd0);

    // writes to x0 are accepted but never reach the RF
    wa[2] = 5'd0; wd[2] = 32'hDEAD_BEEF; req_valid = 3'b100;
    settle();
    check("x0_ready", {29'd0, req_ready}, 32'd4);
    expect_grant(3'b100);
    tick();
    req_valid = 3'b000;
    sb_set = 1'b1; sb_set_addr = 5'd0;
    settle();
    check("x0_we", {31'd0, rf_we}, 32'd0);
    check("x0_setrdy", {31'd0, sb_set_ready}, 32'd1);
    tick();
    sb_set = 1'b0; chk_addr_a = 5'd0;
    settle();
    check("x0_busy", {31'd0, chk_busy_a}, 32'd0);
    wa[2] = 5'd3;

    // single pending write to r9: forward or stall in the write cycle
    chk_addr_a = 5'd9;
    sb_set = 1'b1; sb_set_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    wa[0] = 5'd9; wd[0] = 32'h0000_1234; req_valid = 3'b001;
    settle();
    check("byp_g", {29'd0, req_ready}, 32'd1);
    expect_grant(3'b001);
    tick();
    req_valid = 3'b000;
    settle();
    check("byp_busy", {31'd0, chk_busy_a}, {31'd0, !BYP});
`ifdef TINYGPU_RF_WB_BYPASS_EN
    check("byp_fv", {31'd0, fwd_valid_a}, 32'd1);
    check("byp_fd", fwd_data_a, 32'h0000_1234);
`endif
    tick();
    settle();
    check("byp_busy_after", {31'd0, chk_busy_a}, 32'd0);
`ifdef TINYGPU_RF_WB_BYPASS_EN
    check("byp_fv_after", {31'd0, fwd_valid_a}, 32'd0);
    check("byp_fd_after", fwd_data_a, 32'd0);
`endif

    // reset while a write is in flight clears everything
    chk_addr_a = 5'd10;
    sb_set = 1'b1; sb_set_addr = 5'd10;
    tick(); tick();
    sb_set = 1'b0;
    wa[0] = 5'd10; wd[0] = 32'h1010_1010; req_valid = 3'b001;
    settle();
    check("mid_g", {29'd0, req_ready}, 32'd1);
    expect_grant(3'b001);
    tick();
    rst_n = 1'b0; req_valid = 3'b111;
    settle();
    check("mid_ready", {29'd0, req_ready}, 32'd0);
    tick();
    settle();
    check("mid_we", {31'd0, rf_we}, 32'd0);
    check("mid_busy", {31'd0, chk_busy_a}, 32'd0);
    rst_n = 1'b1; req_valid = 3'b000;
    tick(); tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
